// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared widths, constants and types for the fetch path
package cpu_pkg;
  localparam int INSTR_W = 32;
  localparam int ADDR_W  = 32;

  typedef logic [ADDR_W-1:0]  addr_t;
  typedef logic [INSTR_W-1:0] instr_t;

  localparam addr_t  PC_STEP          = 32'd4;
  localparam instr_t NOP_INSTR        = 32'h0000_0000;
  localparam addr_t  DEFAULT_RESET_PC = 32'h0000_0000;
endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - fetch stage bus: imem port, branch resolution and IF/ID outputs
interface fetch_unit_if;
  import cpu_pkg::*;

  logic   stall;
  logic   resolve_valid;
  logic   branch;
  logic   uncond_branch;
  logic   zero;
  addr_t  branch_pc;
  addr_t  branch_offset;
  addr_t  imem_addr;
  instr_t imem_data;
  addr_t  if_pc;
  instr_t if_instruction;
  logic   if_valid;
  logic   redirect;

  modport master (
    input  stall, resolve_valid, branch, uncond_branch, zero,
    input  branch_pc, branch_offset, imem_data,
    output imem_addr, if_pc, if_instruction, if_valid, redirect
  );

  modport slave (
    output stall, resolve_valid, branch, uncond_branch, zero,
    output branch_pc, branch_offset, imem_data,
    input  imem_addr, if_pc, if_instruction, if_valid, redirect
  );
endinterface

// File: rtl/branch_target.sv
// rtl/branch_target.sv - combinational taken decision and branch target address
module branch_target
  import cpu_pkg::*;
(
  input  logic  resolve_valid,
  input  logic  branch,
  input  logic  uncond_branch,
  input  logic  zero,
  input  addr_t branch_pc,
  input  addr_t branch_offset,
  output logic  taken,
  output addr_t target
);
  // Offset counts words; the add wraps modulo 2^32 so negative offsets just work.
  assign taken  = resolve_valid & (uncond_branch | (branch & zero));
  assign target = branch_pc + (branch_offset << 2);
endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC register and IF/ID pipeline register with branch redirect/flush
module fetch_unit
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = DEFAULT_RESET_PC
) (
  input  logic         clock,
  input  logic         reset_n,
  fetch_unit_if.master bus
);
  addr_t  pc;
  addr_t  target;
  logic   taken;
  addr_t  if_pc_q;
  instr_t if_instr_q;
  logic   if_valid_q;

  branch_target u_branch_target (
    .resolve_valid (bus.resolve_valid),
    .branch        (bus.branch),
    .uncond_branch (bus.uncond_branch),
    .zero          (bus.zero),
    .branch_pc     (bus.branch_pc),
    .branch_offset (bus.branch_offset),
    .taken         (taken),
    .target        (target)
  );

  assign bus.imem_addr      = pc;
  assign bus.redirect       = taken;
  assign bus.if_pc          = if_pc_q;
  assign bus.if_instruction = if_instr_q;
  assign bus.if_valid       = if_valid_q;

  // A taken branch outranks stall: the wrong-path instruction must never survive.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc         <= RESET_PC;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else if (taken) begin
      pc         <= target;
      if_pc_q    <= '0;
      if_instr_q <= NOP_INSTR;
      if_valid_q <= 1'b0;
    end else if (!bus.stall) begin
      pc         <= pc + PC_STEP;
      if_pc_q    <= pc;
      if_instr_q <= bus.imem_data;
      if_valid_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - randomized and directed self-checking bench for fetch_unit
module tb_fetch_unit;
  localparam logic [31:0] MASK = 32'hA5A5_0000;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic        stall = 1'b0, rv = 1'b0, br = 1'b0, ub = 1'b0, zr = 1'b0;
  logic [31:0] bpc = '0, boff = '0;

  logic [31:0] pc_m, ifpc_m, ifi_m;
  logic        ifv_m;

  fetch_unit_if bus ();
  fetch_unit_if bus2 ();

  assign bus.stall         = stall;
  assign bus.resolve_valid = rv;
  assign bus.branch        = br;
  assign bus.uncond_branch = ub;
  assign bus.zero          = zr;
  assign bus.branch_pc     = bpc;
  assign bus.branch_offset = boff;
  assign bus.imem_data     = bus.imem_addr ^ MASK;

  assign bus2.stall         = 1'b0;
  assign bus2.resolve_valid = 1'b0;
  assign bus2.branch        = 1'b0;
  assign bus2.uncond_branch = 1'b0;
  assign bus2.zero          = 1'b0;
  assign bus2.branch_pc     = '0;
  assign bus2.branch_offset = '0;
  assign bus2.imem_data     = bus2.imem_addr ^ MASK;

  fetch_unit #(.RESET_PC(32'h0000_0100)) dut (.clock(clock), .reset_n(reset_n), .bus(bus));
  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  task automatic model_reset();
    pc_m = 32'h100; ifpc_m = '0; ifi_m = '0; ifv_m = 1'b0;
  endtask

  task automatic clear_inputs();
    stall = 0; rv = 0; br = 0; ub = 0; zr = 0; bpc = '0; boff = '0;
  endtask

  // Advance one edge: behavioural model of the stage, then settle past the edge.
  task automatic step();
    logic        tk;
    logic [31:0] tg;
    tk = rv && (ub || (br && zr));
    tg = bpc + boff * 4;
    @(posedge clock);
    if (tk) begin
      pc_m = tg; ifv_m = 0; ifpc_m = 0; ifi_m = 0;
    end else if (!stall) begin
      ifpc_m = pc_m; ifi_m = pc_m ^ MASK; ifv_m = 1; pc_m = pc_m + 4;
    end
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    reset_n = 0;
    model_reset();
    #12;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL rst_addr got=%h want=%h", bus.imem_addr, 32'h100); end
    checks++; if (bus.if_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%b want=0", bus.if_valid); end
    checks++; if (bus.if_pc !== 32'h0 || bus.if_instruction !== 32'h0) begin errors++; $display("FAIL rst_ifid got=%h/%h want=0/0", bus.if_pc, bus.if_instruction); end
    checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL rst_addr2 got=%h want=fffffffc", bus2.imem_addr); end
    @(negedge clock);
    reset_n = 1;
    step();
    checks++; if (bus2.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr got=%h want=0", bus2.imem_addr); end
    checks++; if (bus2.if_pc !== 32'hFFFF_FFFC || bus2.if_instruction !== 32'h5A5A_FFFC) begin errors++; $display("FAIL wrap_ifid got=%h/%h want=fffffffc/5a5afffc", bus2.if_pc, bus2.if_instruction); end
    step();
    step();
    checks++; if (bus.if_pc !== 32'h108 || bus.if_instruction !== 32'hA5A5_0108 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL fetch3 got=%h/%h/%b want=108/a5a50108/1", bus.if_pc, bus.if_instruction, bus.if_valid); end
  endtask

  task automatic test_stall();
    ub = 1; rv = 1; bpc = 32'h0; boff = 32'd4;
    step();
    clear_inputs();
    checks++; if (bus.imem_addr !== 32'h10 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL stall_setup got=%h/%b want=10/0", bus.imem_addr, bus.if_valid); end
    stall = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      checks++; if (bus.imem_addr !== 32'h10 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0) begin errors++; $display("FAIL stall_hold got=%h/%b/%h want=10/0/0", bus.imem_addr, bus.if_valid, bus.if_pc); end
    end
    stall = 0;
    step();
    checks++; if (bus.if_pc !== 32'h10 || bus.if_instruction !== 32'hA5A5_0010 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL stall_resume got=%h/%h/%b want=10/a5a50010/1", bus.if_pc, bus.if_instruction, bus.if_valid); end
  endtask

  task automatic test_cond_branch();
    logic [31:0] prev;
    rv = 1; br = 1; zr = 1; bpc = 32'h20; boff = 32'd5;
    #1;
    checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL cond_redirect got=%b want=1", bus.redirect); end
    step();
    clear_inputs();
    checks++; if (bus.imem_addr !== 32'h34 || bus.if_valid !== 1'b0) begin errors++; $display("FAIL cond_target got=%h/%b want=34/0", bus.imem_addr, bus.if_valid); end
    step();
    checks++; if (bus.if_pc !== 32'h34 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL cond_fetch got=%h/%b want=34/1", bus.if_pc, bus.if_valid); end
    prev = bus.imem_addr;
    rv = 1; br = 1; zr = 0; bpc = 32'h20; boff = 32'd5;
    #1;
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL nottaken_redirect got=%b want=0", bus.redirect); end
    step();
    clear_inputs();
    checks++; if (bus.imem_addr !== prev + 32'd4 || bus.if_valid !== 1'b1) begin errors++; $display("FAIL nottaken_seq got=%h/%b want=%h/1", bus.imem_addr, bus.if_valid, prev + 32'd4); end
  endtask

  task automatic test_uncond_stall();
    rv = 1; ub = 1; stall = 1; bpc = 32'h40; boff = 32'hFFFF_FFFC;
    #1;
    checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL uncond_redirect got=%b want=1", bus.redirect); end
    step();
    clear_inputs();
    checks++; if (bus.imem_addr !== 32'h30 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instruction !== 32'h0) begin errors++; $display("FAIL uncond_flush got=%h/%b/%h/%h want=30/0/0/0", bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instruction); end
  endtask

  task automatic test_ignore_invalid();
    logic [31:0] prev;
    prev = bus.imem_addr;
    rv = 0; ub = 1; br = 1; zr = 1; bpc = 32'h80; boff = 32'd1;
    #1;
    checks++; if (bus.redirect !== 1'b0) begin errors++; $display("FAIL ignore_redirect got=%b want=0", bus.redirect); end
    step();
    clear_inputs();
    checks++; if (bus.imem_addr !== prev + 32'd4 || bus.if_pc !== prev || bus.if_valid !== 1'b1) begin errors++; $display("FAIL ignore_seq got=%h/%h/%b want=%h/%h/1", bus.imem_addr, bus.if_pc, bus.if_valid, prev + 32'd4, prev); end
  endtask

  task automatic test_random();
    logic exp_tk;
    for (int i = 0; i < 300; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      rv    = ($urandom_range(0, 3) == 0);
      br    = 1'($urandom_range(0, 1));
      ub    = 1'($urandom_range(0, 1));
      zr    = 1'($urandom_range(0, 1));
      bpc   = $urandom() & 32'hFFFF_FFFC;
      boff  = ($urandom_range(0, 3) == 0) ? $urandom() : (32'($urandom_range(0, 63)) - 32'd32);
      exp_tk = rv && (ub || (br && zr));
      #1;
      checks++; if (bus.redirect !== exp_tk || bus.imem_addr !== pc_m) begin errors++; $display("FAIL rand_comb[%0d] got=%b/%h want=%b/%h", i, bus.redirect, bus.imem_addr, exp_tk, pc_m); end
      step();
      checks++; if (bus.imem_addr !== pc_m || bus.if_pc !== ifpc_m || bus.if_instruction !== ifi_m || bus.if_valid !== ifv_m) begin errors++; $display("FAIL rand_state[%0d] got=%h/%h/%h/%b want=%h/%h/%h/%b", i, bus.imem_addr, bus.if_pc, bus.if_instruction, bus.if_valid, pc_m, ifpc_m, ifi_m, ifv_m); end
    end
    clear_inputs();
  endtask

  task automatic test_midreset();
    step();
    step();
    rv = 1; ub = 1; bpc = 32'h200; boff = 32'd8;
    #2;
    reset_n = 0;
    #1;
    checks++; if (bus.imem_addr !== 32'h100 || bus.if_valid !== 1'b0 || bus.if_pc !== 32'h0 || bus.if_instruction !== 32'h0) begin errors++; $display("FAIL midrst_clear got=%h/%b/%h/%h want=100/0/0/0", bus.imem_addr, bus.if_valid, bus.if_pc, bus.if_instruction); end
    checks++; if (bus.redirect !== 1'b1) begin errors++; $display("FAIL midrst_redirect got=%b want=1", bus.redirect); end
    checks++; if (bus2.imem_addr !== 32'hFFFF_FFFC || bus2.if_valid !== 1'b0) begin errors++; $display("FAIL midrst_dut2 got=%h/%b want=fffffffc/0", bus2.imem_addr, bus2.if_valid); end
    @(posedge clock);
    #1;
    checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL midrst_hold got=%h want=100", bus.imem_addr); end
    clear_inputs();
    model_reset();
    @(negedge clock);
    reset_n = 1;
    step();
    checks++; if (bus.if_pc !== 32'h100 || bus.if_instruction !== 32'hA5A5_0100 || bus.if_valid !== 1'b1 || bus.imem_addr !== 32'h104) begin errors++; $display("FAIL midrst_restart got=%h/%h/%b/%h want=100/a5a50100/1/104", bus.if_pc, bus.if_instruction, bus.if_valid, bus.imem_addr); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_cond_branch();
    test_uncond_stall();
    test_ignore_invalid();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
